ldtu_mode_scheduler: RTL and testbench
======================================

# ldtu_mode_scheduler

Controller that sequences the LiTe-DTU encoder FSM pair (standard and fallback). It owns the `fallback` mode line and schedules BC0 markers onto `Orbit` / `Orbit_FB`. A mode change or orbit is applied only when the target FSM can accept it, so no BC0 is dropped and no fallback odd/even pair is split. It sits between the TCP/config decoder and the encoder FSM.

## Interface
- `DRAIN_MAX`, 8: maximum cycles spent in a drain state before the mode switch is forced.
- `CLK` input 1: LiTe-DTU clock, rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `fallback_req` input 1: configuration level; 1 requests fallback mode.
- `bc0_in` input 1: single-cycle BC0 marker.
- `fsm_state` input 5: encoder standard FSM `Current_state`.
- `fsm_state_fb` input 4: encoder fallback FSM `Current_state_FB`.
- `fallback` output 1: registered mode line to the encoder FSM.
- `Orbit` output 1: combinational (Mealy) orbit pulse to the standard FSM.
- `Orbit_FB` output 1: registered orbit level to the fallback FSM.
- `switch_busy` output 1: high while in either drain state.
- `orbit_lost` output 1: sticky; a BC0 arrived while one was already pending.
- `drain_timeout` output 1: sticky; a switch was forced by `DRAIN_MAX`.
- `orbit_delay` output 4: `bc0_in`→issue latency of last orbit, saturating at 15 (stats only).
- `orbit_count` output 8: issued orbits, wraps (stats only).

## Operation
Mode FSM states and transitions:
- NORMAL: `fallback`=0. If `fallback_req`=1, go to DRAIN_N.
- DRAIN_N: go to FALLBACK when `orbit_pend`=0 and `fsm_state`≤14. Also go to FALLBACK when the drain counter reaches `DRAIN_MAX`-1; this sets `drain_timeout`. If `fallback_req` falls, return to NORMAL.
- FALLBACK: `fallback`=1. If `fallback_req`=0, go to DRAIN_FB.
- DRAIN_FB: go to NORMAL when `fsm_state_fb`=latency2 (4'b0100) and `Orbit_FB`=0. The same timeout rule applies. If `fallback_req` rises, return to FALLBACK.
- `fallback` is 1 in FALLBACK and DRAIN_FB only. The drain counter clears on entry to each drain state.

Orbit scheduling (single-entry pending flag `orbit_pend`):
- `bc0_in` sets `orbit_pend`. If `orbit_pend` is already set and is not being issued in this cycle, set `orbit_lost` and keep one pending.
- Standard issue: `Orbit` = `orbit_pend` & `fallback`=0 & `fsm_state`≤14 (a state that samples Orbit). Issuing clears `orbit_pend`.
- Fallback issue: with `fallback`=1 and `fsm_state_fb` ∈ {data_odd 4'b0001, data_even 4'b0011}, register `Orbit_FB`=1 for exactly one cycle. That cycle coincides with latency1/latency2. Issuing clears `orbit_pend`.
- A pending orbit survives a mode switch and issues in the first eligible window of the new mode.
- Simultaneous events:
  - `bc0_in` in the issue cycle: the new BC0 becomes pending; no loss.
  - `bc0_in` and `fallback_req` edge in the same cycle: both are accepted; the drain waits for the issue.

## Timing
- Reset values: mode NORMAL, `fallback`=0, `Orbit`=0, `Orbit_FB`=0, `orbit_pend`=0, `switch_busy`=0, `orbit_lost`=0, `drain_timeout`=0, `orbit_delay`=0, `orbit_count`=0.
- Reset asserted mid-operation clears everything on the next edge, including a pending orbit, with no issue.
- `fallback_req`→`switch_busy`: 1 cycle.
- Drain condition true at edge N → `fallback` toggles after edge N.
- `bc0_in` in an eligible standard state: `Orbit` high one cycle later (pending register). Minimum latency is 1, so `orbit_delay`=1.
- `Orbit` is never high when `fallback`=1. `Orbit_FB` is never high when `fallback`=0.

## Configuration
- `LDTU_ORBIT_STATS_EN` defined: the `orbit_delay` counter (saturating) and `orbit_count` counter are implemented.
- `LDTU_ORBIT_STATS_EN` undefined: both outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Structure
- Package `ldtu_pkg` holds:
  - standard state encodings (IDLE..sign_1_bis, bc0_0..bc0_s0_bis);
  - fallback encodings (IDLE_FB..data_even_bc0);
  - mode-FSM encoding;
  - constant `LAST_DATA_STATE`=5'd14.
- Sub-module `ldtu_orbit_pend` contains the pending flag, the lost flag, and the stats counters. Its inputs are the `bc0_in` set and the issue clear.

## Test plan
- Reset, then `bc0_in` with `fsm_state`=2 → `Orbit`=1 one cycle later for 1 cycle; `orbit_count`=1, `orbit_delay`=1.
- `bc0_in` while `fsm_state`=20 (header) for 2 cycles, then 6 → `Orbit` held off, pulses when the state is 6; `orbit_delay`=3.
- `fallback_req`=1 with `fsm_state` cycling 0–14 → `fallback`=1 two cycles after the request; `switch_busy` pulses 1 cycle.
- FALLBACK mode, `bc0_in`, `fsm_state_fb` 1→2 → `Orbit_FB`=1 exactly in the latency1 cycle.
- Two `bc0_in` 1 cycle apart with `fsm_state` stuck at 21 → `orbit_lost`=1 (sticky), only one `Orbit` issued.
- `fallback_req`=0 with `fsm_state_fb` stuck at 1, `DRAIN_MAX`=8 → `fallback` drops after 8 cycles; `drain_timeout`=1.

Source files
------------

// File: rtl/ldtu_pkg.sv
// Shared encodings for the LiTe-DTU encoder FSM pair and the mode scheduler.
// No logic; no latency; no backpressure.
package ldtu_pkg;

  typedef enum logic [4:0] {
    IDLE       = 5'd0,
    sign_0     = 5'd1,
    sign_1     = 5'd2,
    sign_2     = 5'd3,
    sign_3     = 5'd4,
    sign_4     = 5'd5,
    sign_5     = 5'd6,
    sign_6     = 5'd7,
    sign_7     = 5'd8,
    sign_8     = 5'd9,
    sign_9     = 5'd10,
    sign_10    = 5'd11,
    sign_11    = 5'd12,
    sign_0_bis = 5'd13,
    sign_1_bis = 5'd14,
    bc0_0      = 5'd15,
    bc0_1      = 5'd16,
    bc0_2      = 5'd17,
    bc0_3      = 5'd18,
    bc0_4      = 5'd19,
    bc0_5      = 5'd20,
    bc0_s0_bis = 5'd21
  } std_state_e;

  typedef enum logic [3:0] {
    IDLE_FB       = 4'd0,
    data_odd      = 4'd1,
    latency1      = 4'd2,
    data_even     = 4'd3,
    latency2      = 4'd4,
    data_odd_bc0  = 4'd5,
    data_even_bc0 = 4'd6
  } fb_state_e;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DRAIN_N  = 2'd1,
    FALLBACK = 2'd2,
    DRAIN_FB = 2'd3
  } mode_e;

  // Highest standard state that samples Orbit.
  localparam logic [4:0] LAST_DATA_STATE = 5'd14;

  function automatic logic fb_orbit_window(input logic [3:0] st);
    return (st == data_odd) || (st == data_even);
  endfunction

endpackage

// File: rtl/ldtu_orbit_pend.sv
// Single-entry BC0 pending flag with sticky loss flag; stats under LDTU_ORBIT_STATS_EN.
// Latency: bc0_in -> orbit_pend 1 cycle; no backpressure, a second BC0 while pending is dropped.
module ldtu_orbit_pend (
  input  logic       CLK,
  input  logic       rst,
  input  logic       bc0_in,
  input  logic       issue,
  output logic       orbit_pend,
  output logic       orbit_lost,
  output logic [3:0] orbit_delay,
  output logic [7:0] orbit_count
);

  always_ff @(posedge CLK) begin
    if (rst) begin
      orbit_pend <= 1'b0;
      orbit_lost <= 1'b0;
    end else begin
      if (bc0_in)
        orbit_pend <= 1'b1;
      else if (issue)
        orbit_pend <= 1'b0;
      if (bc0_in && orbit_pend && !issue)
        orbit_lost <= 1'b1;
    end
  end

`ifdef LDTU_ORBIT_STATS_EN
  logic [3:0] age;

  // Age of the oldest pending BC0; a dropped BC0 does not restart it.
  always_ff @(posedge CLK) begin
    if (rst) begin
      age         <= 4'd0;
      orbit_delay <= 4'd0;
      orbit_count <= 8'd0;
    end else begin
      if (issue) begin
        orbit_delay <= age;
        orbit_count <= orbit_count + 8'd1;
      end
      if (bc0_in && (!orbit_pend || issue))
        age <= 4'd1;
      else if (orbit_pend && !issue && (age != 4'd15))
        age <= age + 4'd1;
    end
  end
`else
  assign orbit_delay = 4'd0;
  assign orbit_count = 8'd0;
`endif

endmodule

// File: rtl/ldtu_mode_scheduler.sv
// Sequences standard/fallback encoder modes and schedules BC0 onto Orbit/Orbit_FB (stats: LDTU_ORBIT_STATS_EN).
// Latency: Orbit 1 cycle after bc0_in, Orbit_FB 2; orbits and mode switches wait for an eligible FSM state.
module ldtu_mode_scheduler
  import ldtu_pkg::*;
#(
  parameter int DRAIN_MAX = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       fallback_req,
  input  logic       bc0_in,
  input  logic [4:0] fsm_state,
  input  logic [3:0] fsm_state_fb,
  output logic       fallback,
  output logic       Orbit,
  output logic       Orbit_FB,
  output logic       switch_busy,
  output logic       orbit_lost,
  output logic       drain_timeout,
  output logic [3:0] orbit_delay,
  output logic [7:0] orbit_count
);

  localparam int CW = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;

  mode_e         state, state_nxt;
  logic [CW-1:0] drain_cnt;
  logic          orbit_pend, std_ok, drain_expired, force_sw;
  logic          fallback_nxt, fb_issue, issue;

  assign std_ok        = (fsm_state <= LAST_DATA_STATE);
  assign drain_expired = (drain_cnt == CW'(DRAIN_MAX - 1));
  assign fallback_nxt  = (state_nxt == FALLBACK) || (state_nxt == DRAIN_FB);
  // Never launch Orbit_FB on the edge that leaves fallback mode.
  assign fb_issue      = orbit_pend && fallback && fallback_nxt && fb_orbit_window(fsm_state_fb);
  assign issue         = Orbit || fb_issue;

  always_ff @(posedge CLK) begin
    if (rst)
      state <= NORMAL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    force_sw  = 1'b0;
    case (state)
      NORMAL:
        if (fallback_req) state_nxt = DRAIN_N;
      DRAIN_N:
        if (!fallback_req)
          state_nxt = NORMAL;
        else if (!orbit_pend && std_ok)
          state_nxt = FALLBACK;
        else if (drain_expired) begin
          state_nxt = FALLBACK;
          force_sw  = 1'b1;
        end
      FALLBACK:
        if (!fallback_req) state_nxt = DRAIN_FB;
      DRAIN_FB:
        if (fallback_req)
          state_nxt = FALLBACK;
        else if ((fsm_state_fb == latency2) && !Orbit_FB)
          state_nxt = NORMAL;
        else if (drain_expired) begin
          state_nxt = NORMAL;
          force_sw  = 1'b1;
        end
      default:
        state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    switch_busy = (state == DRAIN_N) || (state == DRAIN_FB);
    Orbit       = orbit_pend && !fallback && std_ok;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      fallback      <= 1'b0;
      Orbit_FB      <= 1'b0;
      drain_timeout <= 1'b0;
      drain_cnt     <= '0;
    end else begin
      fallback <= fallback_nxt;
      Orbit_FB <= fb_issue;
      if (force_sw)
        drain_timeout <= 1'b1;
      if (state_nxt != state)
        drain_cnt <= '0;
      else if (switch_busy && !drain_expired)
        drain_cnt <= drain_cnt + CW'(1);
    end
  end

  ldtu_orbit_pend u_orbit_pend (
    .CLK         (CLK),
    .rst         (rst),
    .bc0_in      (bc0_in),
    .issue       (issue),
    .orbit_pend  (orbit_pend),
    .orbit_lost  (orbit_lost),
    .orbit_delay (orbit_delay),
    .orbit_count (orbit_count)
  );

endmodule

// File: tb/tb_ldtu_mode_scheduler.sv
// Directed bench for ldtu_mode_scheduler; stats expectations follow LDTU_ORBIT_STATS_EN.
module tb_ldtu_mode_scheduler;

`ifdef LDTU_ORBIT_STATS_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       fallback_req = 1'b0;
  logic       bc0_in = 1'b0;
  logic [4:0] fsm_state = 5'd0;
  logic [3:0] fsm_state_fb = 4'd0;
  logic       fallback, Orbit, Orbit_FB, switch_busy, orbit_lost, drain_timeout;
  logic [3:0] orbit_delay;
  logic [7:0] orbit_count;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ldtu_mode_scheduler #(.DRAIN_MAX(8)) dut (
    .CLK           (CLK),
    .rst           (rst),
    .fallback_req  (fallback_req),
    .bc0_in        (bc0_in),
    .fsm_state     (fsm_state),
    .fsm_state_fb  (fsm_state_fb),
    .fallback      (fallback),
    .Orbit         (Orbit),
    .Orbit_FB      (Orbit_FB),
    .switch_busy   (switch_busy),
    .orbit_lost    (orbit_lost),
    .drain_timeout (drain_timeout),
    .orbit_delay   (orbit_delay),
    .orbit_count   (orbit_count)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic r, input logic b, input logic [4:0] s, input logic [3:0] f);
    fallback_req = r;
    bc0_in       = b;
    fsm_state    = s;
    fsm_state_fb = f;
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    drv(0, 0, 5'd0, 4'd0);
    cyc(); cyc();
    chk1("rst_fallback", fallback, 1'b0);
    chk1("rst_orbit", Orbit, 1'b0);
    chk1("rst_orbit_fb", Orbit_FB, 1'b0);
    chk1("rst_busy", switch_busy, 1'b0);
    chk1("rst_lost", orbit_lost, 1'b0);
    chk1("rst_timeout", drain_timeout, 1'b0);
    chk8("rst_delay", {4'd0, orbit_delay}, 8'd0);
    chk8("rst_count", orbit_count, 8'd0);

    // BC0 in an eligible standard state: Orbit one cycle later, one cycle wide
    rst = 1'b0;
    drv(0, 1, 5'd2, 4'd0);
    chk1("std_bc0_cycle", Orbit, 1'b0);
    cyc(); drv(0, 0, 5'd2, 4'd0);
    chk1("std_orbit_hi", Orbit, 1'b1);
    cyc(); drv(0, 0, 5'd2, 4'd0);
    chk1("std_orbit_lo", Orbit, 1'b0);
    chk8("std_count", orbit_count, S ? 8'd1 : 8'd0);
    chk8("std_delay", {4'd0, orbit_delay}, S ? 8'd1 : 8'd0);

    // BC0 held off by header states, issues on state 6
    cyc(); drv(0, 1, 5'd20, 4'd0);
    chk1("hold_bc0", Orbit, 1'b0);
    cyc(); drv(0, 0, 5'd20, 4'd0);
    chk1("hold_1", Orbit, 1'b0);
    cyc(); drv(0, 0, 5'd20, 4'd0);
    chk1("hold_2", Orbit, 1'b0);
    cyc(); drv(0, 0, 5'd6, 4'd0);
    chk1("hold_issue", Orbit, 1'b1);
    cyc(); drv(0, 0, 5'd6, 4'd0);
    chk1("hold_done", Orbit, 1'b0);
    chk8("hold_delay", {4'd0, orbit_delay}, S ? 8'd3 : 8'd0);
    chk8("hold_count", orbit_count, S ? 8'd2 : 8'd0);

    // Switch to fallback with no pending orbit
    cyc(); drv(1, 0, 5'd0, 4'd0);
    chk1("sw_req_busy", switch_busy, 1'b0);
    cyc(); drv(1, 0, 5'd1, 4'd0);
    chk1("sw_busy", switch_busy, 1'b1);
    chk1("sw_fb_still0", fallback, 1'b0);
    cyc(); drv(1, 0, 5'd2, 4'd0);
    chk1("sw_fallback", fallback, 1'b1);
    chk1("sw_busy_done", switch_busy, 1'b0);

    // Fallback orbit lands in latency1; Orbit stays gated off
    cyc(); drv(1, 1, 5'd2, 4'd0);
    chk1("fb_bc0_orbit", Orbit, 1'b0);
    cyc(); drv(1, 0, 5'd2, 4'd1);
    chk1("fb_std_gated", Orbit, 1'b0);
    chk1("fb_odd", Orbit_FB, 1'b0);
    cyc(); drv(1, 0, 5'd2, 4'd2);
    chk1("fb_latency1", Orbit_FB, 1'b1);
    cyc(); drv(1, 0, 5'd2, 4'd3);
    chk1("fb_after", Orbit_FB, 1'b0);
    chk8("fb_count", orbit_count, S ? 8'd3 : 8'd0);
    chk8("fb_delay", {4'd0, orbit_delay}, S ? 8'd1 : 8'd0);

    // Drain back to normal blocked by data_odd: forced after DRAIN_MAX cycles
    cyc(); drv(0, 0, 5'd2, 4'd1);
    chk1("to_req_fb", fallback, 1'b1);
    chk1("to_req_busy", switch_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(); drv(0, 0, 5'd2, 4'd1);
      chk1("to_drain_fb", fallback, 1'b1);
      chk1("to_drain_busy", switch_busy, 1'b1);
    end
    chk1("to_not_yet", drain_timeout, 1'b0);
    cyc(); drv(0, 0, 5'd21, 4'd1);
    chk1("to_fallback", fallback, 1'b0);
    chk1("to_busy_off", switch_busy, 1'b0);
    chk1("to_sticky", drain_timeout, 1'b1);

    // Back-to-back BC0 with no eligible state: one lost, one issued
    cyc(); drv(0, 1, 5'd21, 4'd0);
    cyc(); drv(0, 1, 5'd21, 4'd0);
    chk1("lost_pre", orbit_lost, 1'b0);
    chk1("lost_hold", Orbit, 1'b0);
    cyc(); drv(0, 0, 5'd21, 4'd0);
    chk1("lost_set", orbit_lost, 1'b1);
    cyc(); drv(0, 0, 5'd5, 4'd0);
    chk1("lost_issue", Orbit, 1'b1);
    cyc(); drv(0, 0, 5'd5, 4'd0);
    chk1("lost_single", Orbit, 1'b0);
    chk1("lost_sticky", orbit_lost, 1'b1);
    chk8("lost_count", orbit_count, S ? 8'd4 : 8'd0);

    // Reset mid-operation drops a pending orbit
    cyc(); drv(0, 1, 5'd21, 4'd0);
    cyc(); drv(0, 0, 5'd21, 4'd0);
    rst = 1'b1;
    cyc(); rst = 1'b0; drv(0, 0, 5'd5, 4'd0);
    chk1("mrst_no_orbit", Orbit, 1'b0);
    chk1("mrst_lost", orbit_lost, 1'b0);
    chk1("mrst_timeout", drain_timeout, 1'b0);
    chk8("mrst_count", orbit_count, 8'd0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
